// File: rtl/wb_pwm_fader.sv
// wb_pwm_fader: Wishbone-programmed fader that ramps CHANNELS duty-cycle
// values one LSB per prescaler tick toward their targets and pushes each new
// value to a downstream PWM block through a pipelined Wishbone master port.
// Optional build macro WB_PWM_FADER_READBACK_EN enables slave register reads;
// without it wb_dat_o is constant 0.
module wb_pwm_fader #(
  parameter int BITS          = 4,
  parameter int CHANNELS      = 3,
  parameter int PRESCALE_BITS = 16
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        wb_stall_o,
  output logic        m_wb_cyc_o,
  output logic        m_wb_stb_o,
  output logic        m_wb_we_o,
  output logic [31:0] m_wb_adr_o,
  output logic [31:0] m_wb_dat_o,
  input  logic        m_wb_ack_i,
  input  logic        m_wb_stall_i
);

  localparam int IDX_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  typedef enum logic [1:0] {IDLE, SCAN, REQ, WAIT_ACK} state_t;

  state_t                        state_q, state_d;
  logic [IDX_W-1:0]              idx_q, idx_d;
  logic [CHANNELS-1:0][BITS-1:0] tgt_q, cur_q;
  logic [PRESCALE_BITS-1:0]      period_q, cnt_q;
  logic                          pend_q, pend_clr, tick;
  logic                          ack_q;
  logic [31:0]                   rdat_q;
  logic                          slv_req;
  logic [3:0]                    slv_idx;
  logic [BITS-1:0]               cur_sel, tgt_sel;
  logic                          last_ch, step_en, adv;
  logic                          cyc_c, stb_c, bus_c;
  logic                          unused_bits;

  assign slv_req     = wb_cyc_i & wb_stb_i;
  assign slv_idx     = wb_adr_i[5:2];
  assign cur_sel     = cur_q[idx_q];
  assign tgt_sel     = tgt_q[idx_q];
  assign last_ch     = (idx_q == IDX_W'(CHANNELS - 1));
  assign tick        = (cnt_q == '0);
  assign wb_stall_o  = 1'b0;
  assign unused_bits = ^{wb_adr_i[31:6], wb_adr_i[1:0], wb_dat_i};

  // Slave register writes and the single-cycle acknowledge
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      tgt_q    <= '0;
      period_q <= PRESCALE_BITS'(16'h00FF);
      ack_q    <= 1'b0;
    end else begin
      ack_q <= slv_req;
      if (slv_req && wb_we_i) begin
        if (slv_idx == 4'd15)
          period_q <= wb_dat_i[PRESCALE_BITS-1:0];
        else if (slv_idx < 4'(CHANNELS))
          tgt_q[slv_idx[IDX_W-1:0]] <= wb_dat_i[BITS-1:0];
      end
    end
  end

`ifdef WB_PWM_FADER_READBACK_EN
  logic [31:0] rdat_d, cur_pack;

  // Read mux: targets, packed current values, period
  always_comb begin
    cur_pack = '0;
    for (int i = 0; i < CHANNELS; i++) cur_pack[i*BITS +: BITS] = cur_q[i];
    rdat_d = '0;
    if (slv_idx == 4'd15)            rdat_d = 32'(period_q);
    else if (slv_idx == 4'd14)       rdat_d = cur_pack;
    else if (slv_idx < 4'(CHANNELS)) rdat_d = 32'(tgt_q[slv_idx[IDX_W-1:0]]);
  end

  // Read data is registered so it lines up with wb_ack_o
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i)                rdat_q <= '0;
    else if (slv_req && !wb_we_i) rdat_q <= rdat_d;
    else                         rdat_q <= '0;
  end
`else
  assign rdat_q = '0;
`endif

  // Prescaler: tick when the count hits 0, then reload from the period register
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i)  cnt_q <= '0;
    else if (tick) cnt_q <= period_q;
    else           cnt_q <= cnt_q - PRESCALE_BITS'(1);
  end

  // At most one tick is remembered while a sweep is in progress
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i)                       pend_q <= 1'b0;
    else if (pend_clr)                  pend_q <= 1'b0;
    else if (tick && state_q != IDLE)   pend_q <= 1'b1;
  end

  // Sweep FSM next-state and master-bus controls
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    pend_clr = 1'b0;
    step_en  = 1'b0;
    adv      = 1'b0;
    cyc_c    = 1'b0;
    stb_c    = 1'b0;
    bus_c    = 1'b0;
    case (state_q)
      IDLE: begin
        if (tick || pend_q) begin
          state_d  = SCAN;
          idx_d    = '0;
          pend_clr = 1'b1;
        end
      end
      SCAN: begin
        if (cur_sel != tgt_sel) begin
          step_en = 1'b1;
          state_d = REQ;
        end else begin
          adv = 1'b1;
        end
      end
      REQ: begin
        cyc_c = 1'b1;
        stb_c = 1'b1;
        bus_c = 1'b1;
        // an ack coinciding with acceptance completes the write right here
        if (!m_wb_stall_i) begin
          if (m_wb_ack_i) adv = 1'b1;
          else            state_d = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        cyc_c = 1'b1;
        bus_c = 1'b1;
        if (m_wb_ack_i) adv = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    if (adv) begin
      if (last_ch) begin
        state_d = IDLE;
      end else begin
        state_d = SCAN;
        idx_d   = idx_q + IDX_W'(1);
      end
    end
  end

  // FSM state and channel index registers
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // One-LSB step toward target; SCAN only steps when they differ, so no wrap
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      cur_q <= '0;
    end else if (step_en) begin
      if (cur_sel < tgt_sel) cur_q[idx_q] <= cur_sel + BITS'(1);
      else                   cur_q[idx_q] <= cur_sel - BITS'(1);
    end
  end

  // Outputs are forced quiet while reset is asserted so an in-flight
  // master cycle is dropped in the reset cycle itself
  assign m_wb_cyc_o = cyc_c & ~wb_rst_i;
  assign m_wb_stb_o = stb_c & ~wb_rst_i;
  assign m_wb_we_o  = bus_c & ~wb_rst_i;
  assign m_wb_adr_o = (bus_c && !wb_rst_i) ? 32'({idx_q, 2'b00}) : 32'd0;
  assign m_wb_dat_o = (bus_c && !wb_rst_i) ? 32'(cur_sel) : 32'd0;
  assign wb_ack_o   = ack_q & ~wb_rst_i;
  assign wb_dat_o   = wb_rst_i ? 32'd0 : rdat_q;

endmodule

// File: tb/tb_wb_pwm_fader.sv
// Directed bench for wb_pwm_fader: a responder models the downstream PWM
// slave (optional stall, ack next cycle / same cycle / never) and logs every
// accepted master write; the main sequence queues expected writes and
// compares them against the log.
module tb_wb_pwm_fader;

`ifdef WB_PWM_FADER_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [31:0] adr = '0, dat = '0;
  logic [31:0] rdat;
  logic        ack, stall_o;
  logic        m_cyc, m_stb, m_we;
  logic [31:0] m_adr, m_dat;
  logic        m_ack = 1'b0, m_stall = 1'b0;

  always #5 clk = ~clk;

  wb_pwm_fader #(.BITS(4), .CHANNELS(3), .PRESCALE_BITS(16)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we),
    .wb_adr_i(adr), .wb_dat_i(dat), .wb_dat_o(rdat),
    .wb_ack_o(ack), .wb_stall_o(stall_o),
    .m_wb_cyc_o(m_cyc), .m_wb_stb_o(m_stb), .m_wb_we_o(m_we),
    .m_wb_adr_o(m_adr), .m_wb_dat_o(m_dat),
    .m_wb_ack_i(m_ack), .m_wb_stall_i(m_stall)
  );

  logic [63:0] exp_q[$];
  logic [63:0] obs_q[$];
  int          obs_t[$];
  int          passes = 0, fails = 0, sb_idx = 0, cyc_cnt = 0;
  bit          ack_now = 1'b0, ack_off = 1'b0;
  int          stall_n = 0, stall_gen = 0;
  int          stall_left = 0, stall_seen = 0;
  bit          ack_next = 1'b0, accept;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // Downstream slave model and write logger
  always @(negedge clk) begin
    if (stall_seen != stall_gen) begin
      stall_left = stall_n;
      stall_seen = stall_gen;
    end
    if (m_stb && stall_left > 0) begin
      m_stall = 1'b1;
      stall_left--;
    end else begin
      m_stall = 1'b0;
    end
    accept = m_cyc && m_stb && !m_stall;
    if (ack_off) begin
      m_ack = 1'b0; ack_next = 1'b0;
    end else if (ack_now) begin
      m_ack = accept; ack_next = 1'b0;
    end else begin
      m_ack = ack_next; ack_next = accept;
    end
    if (accept && m_we) begin
      obs_q.push_back({m_adr, m_dat});
      obs_t.push_back(cyc_cnt);
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    assert (obs === expv) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, expv);
    end
  endtask

  task automatic expw(input logic [31:0] a, input logic [31:0] d);
    exp_q.push_back({a, d});
  endtask

  task automatic wb_wr(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = a; dat = d;
    @(negedge clk);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    chk("wr_ack", ack, 1);
  endtask

  task automatic wb_rd(input string tag, input logic [31:0] a, input logic [31:0] expd);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = a;
    @(negedge clk);
    cyc = 1'b0; stb = 1'b0;
    chk({tag, "_ack"}, ack, 1);
    chk(tag, rdat, expd);
  endtask

  // Wait (bounded) for all queued writes, idle a while, then score the log
  task automatic drain(input string tag, input int idle);
    int n = 0;
    while (obs_q.size() < exp_q.size() && n < 3000) begin
      @(negedge clk);
      n++;
    end
    repeat (idle) @(negedge clk);
    chk({tag, "_count"}, obs_q.size(), exp_q.size());
    while (sb_idx < exp_q.size()) begin
      if (sb_idx < obs_q.size()) chk(tag, obs_q[sb_idx], exp_q[sb_idx]);
      sb_idx++;
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_cyc"}, m_cyc, 0);
    chk({tag, "_stb"}, m_stb, 0);
    chk({tag, "_we"},  m_we, 0);
    chk({tag, "_adr"}, m_adr, 0);
    chk({tag, "_dat"}, m_dat, 0);
    chk({tag, "_ack"}, ack, 0);
    chk({tag, "_rdat"}, rdat, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, base;
    // reset state
    repeat (3) @(negedge clk);
    chk_quiet("in_reset");
    chk("stall_tied", stall_o, 0);
    rst = 1'b0;
    @(negedge clk);
    chk_quiet("post_reset");

    // ramp channel 0 from 0 to 3 with period 0
    wb_wr(32'h3C, 32'd0);
    expw(32'h0, 1); expw(32'h0, 2); expw(32'h0, 3);
    wb_wr(32'h0, 32'd3);
    drain("ramp_ch0", 20);
    chk("idle_after_ramp", m_cyc, 0);

    // channel 1 up to 5, then down to 2; nothing on 0x0 or 0x8
    for (int v = 1; v <= 5; v++) expw(32'h4, v);
    wb_wr(32'h4, 32'd5);
    drain("up_ch1", 10);
    expw(32'h4, 4); expw(32'h4, 3); expw(32'h4, 2);
    wb_wr(32'h4, 32'd2);
    drain("down_ch1", 20);
    wb_rd("rd_tgt0", 32'h0, RB ? 32'd3 : 32'd0);
    wb_rd("rd_tgt1", 32'h4, RB ? 32'd2 : 32'd0);
    wb_rd("rd_unmapped", 32'h30, 32'd0);

    // stall for 4 cycles on a REQ: stb, adr, dat held
    stall_n = 4; stall_gen++;
    expw(32'h8, 1);
    wb_wr(32'h8, 32'd1);
    n = 0;
    while (!m_stb && n < 200) begin @(negedge clk); n++; end
    chk("stall_req_seen", m_stb, 1);
    for (int i = 0; i < 4; i++) begin
      chk("stall_stb", m_stb, 1);
      chk("stall_adr", m_adr, 32'h8);
      chk("stall_dat", m_dat, 32'h1);
      @(negedge clk);
    end
    drain("stall_write", 10);

    // ack in the same cycle the request is accepted
    ack_now = 1'b1;
    expw(32'h8, 2); expw(32'h8, 3);
    wb_wr(32'h8, 32'd3);
    drain("same_cycle_ack", 10);
    ack_now = 1'b0;
    wb_rd("rd_cur_pack", 32'h38, RB ? 32'h323 : 32'd0);

    // period 2: sweeps chain back to back through the pending flag
    wb_wr(32'h3C, 32'd200);
    repeat (20) @(negedge clk);
    wb_wr(32'h0, 32'd9); wb_wr(32'h4, 32'd8); wb_wr(32'h8, 32'd9);
    base = obs_q.size();
    for (int k = 0; k < 6; k++) begin
      expw(32'h0, 4 + k); expw(32'h4, 3 + k); expw(32'h8, 4 + k);
    end
    wb_wr(32'h3C, 32'd2);
    drain("pending_sweeps", 20);
    for (int k = 1; k < 6; k++)
      if (base + 3 * k < obs_t.size())
        chk("sweep_gap", obs_t[base + 3 * k] - obs_t[base + 3 * (k - 1)], 10);
      else
        chk("sweep_gap_missing", obs_t.size(), base + 3 * k + 1);
    wb_rd("rd_period2", 32'h3C, RB ? 32'd2 : 32'd0);

    // reset while the master waits for an ack
    ack_off = 1'b1;
    expw(32'h0, 8);
    wb_wr(32'h0, 32'd0);
    n = 0;
    while (!(m_cyc && !m_stb) && n < 200) begin @(negedge clk); n++; end
    chk("wait_ack_seen", m_cyc && !m_stb, 1);
    rst = 1'b1;
    @(negedge clk);
    chk_quiet("rst_in_wait");
    rst = 1'b0;
    @(negedge clk);
    chk_quiet("after_rst_wait");
    ack_off = 1'b0;
    drain("quiet_after_reset", 300);
    wb_rd("rd_period_rst", 32'h3C, RB ? 32'h00FF : 32'd0);
    wb_rd("rd_cur_rst", 32'h38, 32'd0);

    $display("%0d/%0d checks passed", passes, passes + fails);
    $finish;
  end

endmodule

// File: doc/wb_pwm_fader.md
WB_PWM_FADER -- requirements
Module: wb_pwm_fader

Interface
REQ-001 Parameters SHALL be, one per line:
- BITS, 4, width of each duty-cycle value.
- CHANNELS, 3, number of PWM channels sequenced (1..8).
- PRESCALE_BITS, 16, width of the step-period register.
REQ-002 Ports SHALL be, one per line:
- wb_clk_i  in  1  single clock.
- wb_rst_i  in  1  reset, synchronous, active-high.
- wb_cyc_i, wb_stb_i, wb_we_i  in  1 each  slave request (Wishbone B4 pipelined).
- wb_adr_i  in  32  slave byte address.
- wb_dat_i  in  32  slave write data.
- wb_dat_o  out  32  slave read data.
- wb_ack_o  out  1  slave acknowledge.
- wb_stall_o  out  1  slave stall, tied 0.
- m_wb_cyc_o, m_wb_stb_o, m_wb_we_o  out  1 each  master request toward the PWM block.
- m_wb_adr_o  out  32  master address, channel i at i*4.
- m_wb_dat_o  out  32  master write data, duty in [BITS-1:0], upper bits 0.
- m_wb_ack_i, m_wb_stall_i  in  1 each  master acknowledge and stall.

Function
REQ-003 Slave map SHALL be word index wb_adr_i[5:2]: index i < CHANNELS = target[i] (BITS wide, from wb_dat_i[BITS-1:0]); index 15 = period (PRESCALE_BITS wide); other indices: writes ignored.
REQ-004 wb_ack_o SHALL assert exactly one cycle after each cycle with wb_cyc_i & wb_stb_i, for reads and writes alike.
REQ-005 The prescaler SHALL count down from period to 0, then reload; a tick SHALL occur in the cycle the count is 0; period 0 SHALL tick every cycle.
REQ-006 A tick arriving while the FSM is not IDLE SHALL set a single pending flag; further ticks while pending SHALL be dropped.
REQ-007 The FSM states SHALL be IDLE, SCAN, REQ, WAIT_ACK.
- IDLE: on tick or pending -> SCAN, clear pending, channel index = 0.
- SCAN: if current[idx] != target[idx], step current[idx] by +1 or -1 toward target -> REQ; else advance idx; after the last channel -> IDLE.
- REQ: m_wb_cyc_o = m_wb_stb_o = m_wb_we_o = 1, adr = idx*4, dat = current[idx]; stay while m_wb_stall_i = 1; else -> WAIT_ACK, stb drops.
- WAIT_ACK: cyc held; on m_wb_ack_i drop cyc, advance idx -> SCAN, or -> IDLE after the last channel.
REQ-008 Each channel SHALL move by at most one LSB per tick; current SHALL never pass target, and arithmetic SHALL not wrap (0 toward 0, max toward max: no step, no write).
REQ-009 A target write during a sweep SHALL be used at that channel's next SCAN evaluation; there is no restart.
REQ-010 An ack arriving in the same cycle that REQ is accepted SHALL be honoured: -> SCAN directly, no hang.
REQ-011 Writes to the period register SHALL take effect at the next reload.

Reset
REQ-012 On wb_rst_i (synchronous), all targets, all current values, the prescaler and the pending flag SHALL clear, period SHALL load 0x00FF, FSM -> IDLE, idx = 0.
REQ-013 During reset, and in the cycle after it, wb_ack_o, m_wb_cyc_o, m_wb_stb_o and m_wb_we_o SHALL be 0, m_wb_adr_o = 0, m_wb_dat_o = 0, wb_dat_o = 0; a master transaction in flight SHALL be abandoned.

Configuration
REQ-014 Macro WB_PWM_FADER_READBACK_EN:
- Defined: reads SHALL return target[i] at index i, period at index 15, and {CHANNELS current values packed BITS each} at index 14, zero-extended.
- Undefined: wb_dat_o SHALL be constant 0; write and ack behaviour unchanged.

Verification
REQ-015 Reset, then period = 0, target[0] = 3, no stall, ack one cycle after stb -> exactly three master writes to 0x0 with data 1, 2, 3, then idle.
REQ-016 current[1] = 5, target[1] = 2 -> writes to 0x4 with data 4, 3, 2, one per tick; no writes to 0x0 or 0x8.
REQ-017 m_wb_stall_i high for 4 cycles during REQ -> stb held, adr and dat stable for 4 cycles; a single write is accepted; ack completes it.
REQ-018 period = 2, all channels differing -> ticks 3 cycles apart; a tick arriving during a sweep sets pending; a second tick during the same sweep is dropped; the next sweep starts immediately after IDLE.
REQ-019 wb_rst_i asserted while in WAIT_ACK -> cyc = 0 in the next cycle, all current values 0, no further writes; with READBACK_EN, read of index 15 returns 0x00FF.
